// File: rtl/fp_mul_issue_arb.sv
// Issue controller for a pipelined FP multiplier: round-robin pick of two requesters, valid/id
// tracking alongside the datapath, back-pressure stall and synchronous flush.
module fp_mul_issue_arb #(
  parameter int unsigned DW  = 16,
  parameter int unsigned LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_opa,
  input  logic [DW-1:0] req0_opb,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_opa,
  input  logic [DW-1:0] req1_opb,
  input  logic          flush,
  output logic          mul_en,
  output logic [DW-1:0] mul_opa,
  output logic [DW-1:0] mul_opb,
  input  logic [DW-1:0] mul_res,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_id,
  output logic [3:0]    inflight,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2,
    StFlush = 2'd3
  } state_e;

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] id_q;
  logic           rr_q;
  logic [3:0]     inflight_q;
  logic [3:0]     inflight_d;
  state_e         state_q;

  logic grant0, grant1, issue_ok;
  logic acc0, acc1, accept, consume;

  // rr_q holds the last granted requester; on contention the other one wins.
  assign grant0   = req0_valid & (~req1_valid | rr_q);
  assign grant1   = req1_valid & (~req0_valid | ~rr_q);
  assign mul_en   = ~(vld_q[LAT-1] & ~res_ready);
  assign issue_ok = mul_en & ~flush & (state_q != StFlush);

  assign req0_ready = grant0 & issue_ok;
  assign req1_ready = grant1 & issue_ok;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign accept     = acc0 | acc1;

  assign mul_opa = acc1 ? req1_opa : req0_opa;
  assign mul_opb = acc1 ? req1_opb : req0_opb;

  assign res_valid = vld_q[LAT-1];
  assign res_id    = id_q[LAT-1];
  assign res_data  = mul_res;
  assign consume   = res_valid & res_ready;

  assign inflight = inflight_q;
  assign state    = state_q;

  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = 4'd0;
    end else if (accept && !consume) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!accept && consume) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      id_q       <= '0;
      rr_q       <= 1'b0;
      inflight_q <= 4'd0;
      state_q    <= StIdle;
    end else begin
      inflight_q <= inflight_d;
      if (flush) begin
        vld_q <= '0;
      end else if (mul_en) begin
        vld_q <= {vld_q[LAT-2:0], accept};
        id_q  <= {id_q[LAT-2:0], acc1};
        if (accept) begin
          rr_q <= acc1;
        end
      end

      if (flush) begin
        state_q <= StFlush;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              state_q <= StRun;
            end
          end
          StRun: begin
            if (!mul_en) begin
              state_q <= StStall;
            end else if (inflight_d == 4'd0 && !accept) begin
              state_q <= StIdle;
            end
          end
          StStall: begin
            if (res_ready) begin
              state_q <= StRun;
            end
          end
          StFlush: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_issue_arb.sv
// Directed bench for fp_mul_issue_arb with a behavioural LAT-deep multiplier pipe on mul_*.
module tb_fp_mul_issue_arb;

  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic          flush, mul_en;
  logic [DW-1:0] mul_opa, mul_opb, mul_res;
  logic          res_valid, res_ready, res_id;
  logic [DW-1:0] res_data;
  logic [3:0]    inflight;
  logic [1:0]    state;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  fp_mul_issue_arb #(.DW(DW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_opa   (req0_opa),
    .req0_opb   (req0_opb),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_opa   (req1_opa),
    .req1_opb   (req1_opb),
    .flush      (flush),
    .mul_en     (mul_en),
    .mul_opa    (mul_opa),
    .mul_opb    (mul_opb),
    .mul_res    (mul_res),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .inflight   (inflight),
    .state      (state)
  );

  // Products for the operand pairs used here, computed by hand.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h4000 && b == 16'h4200) return 16'h4600;
    if (a == 16'h3E00 && b == 16'h3E00) return 16'h4080;
    if (a == 16'h4000 && b == 16'h4000) return 16'h4400;
    return 16'h0BAD;
  endfunction

  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (mul_en) begin
      pipe[0] <= fmul(mul_opa, mul_opb);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_res = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opa = '0; req0_opb = '0; req1_opa = '0; req1_opb = '0;
    #2;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_mul_en", 32'(mul_en), 1);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_state", 32'(state), 0);
    #10 rst_n = 1'b1;
    tick();

    // Single request from requester 0: 2.0 * 3.0
    req0_valid = 1'b1; req0_opa = 16'h4000; req0_opb = 16'h4200;
    #1;
    chk("t1_ready", 32'(req0_ready), 1);
    chk("t1_opa", 32'(mul_opa), 32'h4000);
    chk("t1_opb", 32'(mul_opb), 32'h4200);
    tick();
    req0_valid = 1'b0;
    chk("t1_state_run", 32'(state), 1);
    chk("t1_inflight", 32'(inflight), 1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t1_no_res_%0d", i), 32'(res_valid), 0);
      tick();
    end
    chk("t1_res_valid", 32'(res_valid), 1);
    chk("t1_res_data", 32'(res_data), 32'h4600);
    chk("t1_res_id", 32'(res_id), 0);
    tick();
    chk("t1_drained", 32'(res_valid), 0);
    chk("t1_inflight0", 32'(inflight), 0);
    chk("t1_idle", 32'(state), 0);

    // Single request from requester 1 (leaves rr at 1)
    req1_valid = 1'b1; req1_opa = 16'h4000; req1_opb = 16'h4000;
    #1;
    chk("t1b_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    tick(); tick(); tick();
    chk("t1b_res_valid", 32'(res_valid), 1);
    chk("t1b_res_data", 32'(res_data), 32'h4400);
    chk("t1b_res_id", 32'(res_id), 1);
    tick();

    // Both streaming: grants alternate, full pipe accepts and consumes together
    req0_valid = 1'b1; req0_opa = 16'h3E00; req0_opb = 16'h3E00;
    req1_valid = 1'b1; req1_opa = 16'h4000; req1_opb = 16'h4000;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("st_r0_%0d", k), 32'(req0_ready), 32'(k % 2 == 0));
      chk($sformatf("st_r1_%0d", k), 32'(req1_ready), 32'(k % 2 == 1));
      chk($sformatf("st_opa_%0d", k), 32'(mul_opa), (k % 2 == 1) ? 32'h4000 : 32'h3E00);
      chk($sformatf("st_infl_%0d", k), 32'(inflight), (k < 4) ? 32'(k) : 32'd4);
      chk($sformatf("st_rv_%0d", k), 32'(res_valid), 32'(k >= 4));
      if (k >= 4) begin
        chk($sformatf("st_id_%0d", k), 32'(res_id), 32'(k % 2));
        chk($sformatf("st_data_%0d", k), 32'(res_data), (k % 2 == 1) ? 32'h4400 : 32'h4080);
      end
      tick();
    end

    // Back-pressure on a full pipe
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("stall_en_%0d", s), 32'(mul_en), 0);
      chk($sformatf("stall_r0_%0d", s), 32'(req0_ready), 0);
      chk($sformatf("stall_r1_%0d", s), 32'(req1_ready), 0);
      chk($sformatf("stall_rv_%0d", s), 32'(res_valid), 1);
      chk($sformatf("stall_id_%0d", s), 32'(res_id), 0);
      chk($sformatf("stall_data_%0d", s), 32'(res_data), 32'h4080);
      chk($sformatf("stall_infl_%0d", s), 32'(inflight), 4);
      if (s > 0) chk($sformatf("stall_state_%0d", s), 32'(state), 2);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("rel_state", 32'(state), 2);
    chk("rel_en", 32'(mul_en), 1);
    chk("rel_r0", 32'(req0_ready), 1);
    chk("rel_id", 32'(res_id), 0);
    chk("rel_data", 32'(res_data), 32'h4080);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      #1;
      chk($sformatf("drain_rv_%0d", d), 32'(res_valid), 1);
      chk($sformatf("drain_id_%0d", d), 32'(res_id), 32'(d % 2 == 0));
      chk($sformatf("drain_data_%0d", d), 32'(res_data), (d % 2 == 0) ? 32'h4400 : 32'h4080);
      chk($sformatf("drain_state_%0d", d), 32'(state), 1);
      tick();
    end
    chk("drain_end_rv", 32'(res_valid), 0);
    chk("drain_end_infl", 32'(inflight), 0);
    chk("drain_end_state", 32'(state), 0);

    // Flush with two entries in flight
    req0_valid = 1'b1; req0_opa = 16'h4000; req0_opb = 16'h4200;
    #1;
    chk("fl_acc0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    #1;
    chk("fl_acc1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0; req0_valid = 1'b1; flush = 1'b1;
    #1;
    chk("fl_infl2", 32'(inflight), 2);
    chk("fl_noready", 32'(req0_ready), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_state", 32'(state), 3);
    chk("fl_infl0", 32'(inflight), 0);
    chk("fl_rv", 32'(res_valid), 0);
    chk("fl_noready2", 32'(req0_ready), 0);
    tick();
    req0_opa = 16'h3E00; req0_opb = 16'h3E00;
    #1;
    chk("fl_idle", 32'(state), 0);
    chk("fl_new_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fl_quiet_%0d", i), 32'(res_valid), 0);
      tick();
    end
    #1;
    chk("fl_new_rv", 32'(res_valid), 1);
    chk("fl_new_data", 32'(res_data), 32'h4080);
    chk("fl_new_id", 32'(res_id), 0);
    tick();
    chk("fl_new_done", 32'(inflight), 0);

    // Asynchronous reset with three in flight
    req0_valid = 1'b1; req0_opa = 16'h4000; req0_opb = 16'h4200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ar_ready_%0d", i), 32'(req0_ready), 1);
      tick();
    end
    req0_valid = 1'b0;
    chk("ar_infl3", 32'(inflight), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_infl", 32'(inflight), 0);
    chk("ar_state", 32'(state), 0);
    chk("ar_rv", 32'(res_valid), 0);
    chk("ar_mul_en", 32'(mul_en), 1);
    #10 rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk($sformatf("ar_stale_%0d", i), 32'(res_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
